// File: rtl/hp1349a_bus_rx.sv
// hp1349a_bus_rx -- receiver for the HP1349A-style LDAV/LRFD parallel word
// handshake feeding a display-list FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   enable            allows a new transfer to start from IDLE
//   clear_err         pulse: clears sticky flags and drop_count
//   DATA, LDAV        asynchronous source bus and data-available strobe
//   LRFD              ready-for-data, active low
//   fifo_full         downstream back-pressure
//   fifo_write_en     one-cycle write strobe
//   fifo_write_data   {overrun_mark, DATA}, held between writes
//   read_state_r      FSM state, busy = state != IDLE
//   word_count        words written (wraps), drop_count words dropped (saturates)
//   overrun_err, timeout_err   sticky error flags
module hp1349a_bus_rx #(
   parameter int DATA_W         = 15,
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 2,
   parameter int HOLDOFF_CYCLES = 255,
   parameter int ACK_TIMEOUT    = 1023,
   parameter bit DROP_ON_FULL   = 1'b0,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear_err,
   input  logic [DATA_W-1:0] DATA,
   input  logic              LDAV,
   output logic              LRFD,
   input  logic              fifo_full,
   output logic              fifo_write_en,
   output logic [DATA_W:0]   fifo_write_data,
   output logic [2:0]        read_state_r,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              overrun_err,
   output logic              timeout_err
);

   // One down-counter serves the ACK timer, settle delay and holdoff, since
   // only one of them is live in any state.
   localparam int M1   = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
   localparam int MAXC = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
   localparam int TW   = $clog2(MAXC + 2);

   // Timer reaches 0 on the ACK_TIMEOUT-th ACK cycle, which is when we give up.
   localparam logic [TW-1:0] ACK_LD    = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] HOLD_LD   = TW'(HOLDOFF_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACK    = 3'd1,
      S_SETTLE = 3'd2,
      S_WAIT   = 3'd3,
      S_WRITE  = 3'd4,
      S_HOLD   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                rfd_q, rfd_d;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [DATA_W:0]     wdata_q, wdata_d;
   logic [CNT_W-1:0]    wc_q, wc_d;
   logic [CNT_W-1:0]    dc_q, dc_d;
   logic                oe_q, oe_d;
   logic                te_q, te_d;
   logic                mark_q, mark_d;
   logic                ldav_s;

   assign ldav_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rfd_q   <= 1'b0;
         cnt_q   <= '0;
         sync_q  <= '0;
         wdata_q <= '0;
         wc_q    <= '0;
         dc_q    <= '0;
         oe_q    <= 1'b0;
         te_q    <= 1'b0;
         mark_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rfd_q   <= rfd_d;
         cnt_q   <= cnt_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], LDAV};
         wdata_q <= wdata_d;
         wc_q    <= wc_d;
         dc_q    <= dc_d;
         oe_q    <= oe_d;
         te_q    <= te_d;
         mark_q  <= mark_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rfd_d   = rfd_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      wc_d    = wc_q;
      dc_d    = dc_q;
      oe_d    = oe_q;
      te_d    = te_q;
      mark_d  = mark_q;

      // Applied first so a same-cycle drop or timeout overrides the clear.
      if (clear_err) begin
         oe_d = 1'b0;
         te_d = 1'b0;
         dc_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            // Level sensitive: LDAV still high after holdoff starts a new word.
            if (enable && ldav_s) begin
               rfd_d   = 1'b1;
               cnt_d   = ACK_LD;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!ldav_s) begin
               cnt_d   = SETTLE_LD;
               state_d = S_SETTLE;
            end else if (ACK_TIMEOUT != 0) begin
               if (cnt_q == '0) begin
                  rfd_d   = 1'b0;
                  te_d    = 1'b1;
                  cnt_d   = HOLD_LD;
                  state_d = S_HOLD;
               end else begin
                  cnt_d = cnt_q - TW'(1);
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               wdata_d = {mark_q, DATA};
               rfd_d   = 1'b0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - TW'(1);
            end
         end
         S_WAIT: begin
            if (!fifo_full) begin
               state_d = S_WRITE;
            end else if (DROP_ON_FULL) begin
               dc_d    = (&dc_d) ? dc_d : dc_d + CNT_W'(1);
               oe_d    = 1'b1;
               mark_d  = 1'b1;
               cnt_d   = HOLD_LD;
               state_d = S_HOLD;
            end
         end
         S_WRITE: begin
            wc_d    = wc_q + CNT_W'(1);
            mark_d  = 1'b0;
            cnt_d   = HOLD_LD;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - TW'(1);
         end
         default: begin
            state_d = S_IDLE;
            rfd_d   = 1'b0;
         end
      endcase
   end

   assign LRFD            = ~rfd_q;
   assign fifo_write_en   = (state_q == S_WRITE);
   assign fifo_write_data = wdata_q;
   assign read_state_r    = state_q;
   assign busy            = (state_q != S_IDLE);
   assign word_count      = wc_q;
   assign drop_count      = dc_q;
   assign overrun_err     = oe_q;
   assign timeout_err     = te_q;

endmodule

// File: tb/tb_hp1349a_bus_rx.sv
// Bench for hp1349a_bus_rx: one stall-mode and one drop-mode instance, driven
// by transaction tasks. The reference is a per-transfer outcome model (expected
// write queue, counters, flags) plus timing constants derived from the
// handshake rules for SYNC=2, SETTLE=3, HOLDOFF=8, ACK_TIMEOUT=16.
module tb_hp1349a_bus_rx;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       en, clr, ldav, full;
   logic [1:0][14:0] data;
   wire  [1:0]       lrfd, we, busy, oe, te;
   wire  [1:0][15:0] wd, wc, dc;
   wire  [1:0][2:0]  st;

   int n_chk = 0;
   int n_err = 0;

   // Reference model
   logic [15:0] m_wc [2];
   logic [15:0] m_dc [2];
   logic        m_oe [2];
   logic        m_te [2];
   logic        m_mark [2];
   logic [15:0] expq [2][$];

   always #5 clk = ~clk;

   hp1349a_bus_rx #(.DATA_W(15), .SYNC_STAGES(2), .SETTLE_CYCLES(3), .HOLDOFF_CYCLES(8),
                    .ACK_TIMEOUT(16), .DROP_ON_FULL(1'b0), .CNT_W(16)) u_stall (
      .clk(clk), .rst(rst), .enable(en[0]), .clear_err(clr[0]), .DATA(data[0]),
      .LDAV(ldav[0]), .LRFD(lrfd[0]), .fifo_full(full[0]), .fifo_write_en(we[0]),
      .fifo_write_data(wd[0]), .read_state_r(st[0]), .busy(busy[0]),
      .word_count(wc[0]), .drop_count(dc[0]), .overrun_err(oe[0]), .timeout_err(te[0]));

   hp1349a_bus_rx #(.DATA_W(15), .SYNC_STAGES(2), .SETTLE_CYCLES(3), .HOLDOFF_CYCLES(8),
                    .ACK_TIMEOUT(16), .DROP_ON_FULL(1'b1), .CNT_W(16)) u_drop (
      .clk(clk), .rst(rst), .enable(en[1]), .clear_err(clr[1]), .DATA(data[1]),
      .LDAV(ldav[1]), .LRFD(lrfd[1]), .fifo_full(full[1]), .fifo_write_en(we[1]),
      .fifo_write_data(wd[1]), .read_state_r(st[1]), .busy(busy[1]),
      .word_count(wc[1]), .drop_count(dc[1]), .overrun_err(oe[1]), .timeout_err(te[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_wc[k] = '0; m_dc[k] = '0; m_oe[k] = 1'b0; m_te[k] = 1'b0; m_mark[k] = 1'b0;
         expq[k].delete();
      end
   endtask

   task automatic chk_reset_state(input int k);
      chk("rst_lrfd", lrfd[k], 1'b1);
      chk("rst_we",   we[k],   1'b0);
      chk("rst_wd",   wd[k],   16'h0);
      chk("rst_st",   st[k],   3'd0);
      chk("rst_wc",   wc[k],   16'h0);
      chk("rst_dc",   dc[k],   16'h0);
      chk("rst_oe",   oe[k],   1'b0);
      chk("rst_te",   te[k],   1'b0);
   endtask

   task automatic chk_regs(input int k);
      chk("word_count",  wc[k],   m_wc[k]);
      chk("drop_count",  dc[k],   m_dc[k]);
      chk("overrun_err", oe[k],   m_oe[k]);
      chk("timeout_err", te[k],   m_te[k]);
      chk("lrfd_idle",   lrfd[k], 1'b1);
   endtask

   task automatic wait_idle(input int k);
      for (int i = 0; i < 60 && busy[k]; i++) @(negedge clk);
      chk("idle_wait", busy[k], 1'b0);
   endtask

   // Raise LDAV on an idle DUT and return how many negedges until LRFD fell.
   task automatic raise_ldav(input int k, output int n);
      n = 0;
      data[k] = 15'($urandom);
      ldav[k] = 1'b1;
      while (lrfd[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One full transfer. full_cyc > 0 holds fifo_full from LDAV release.
   task automatic xfer(input int k, input logic [14:0] d, input int full_cyc);
      int n;
      wait_idle(k);
      raise_ldav(k, n);
      chk("lrfd_fall_lat", n, 3);
      cyc($urandom_range(0, 4));
      ldav[k] = 1'b0;
      data[k] = ~d;                       // wrong value until just after release
      full[k] = (full_cyc > 0);
      if (full_cyc > 0 && k == 1) begin
         m_dc[k]   = (m_dc[k] == 16'hFFFF) ? m_dc[k] : m_dc[k] + 16'd1;
         m_oe[k]   = 1'b1;
         m_mark[k] = 1'b1;
      end else begin
         expq[k].push_back({m_mark[k], d});
         m_mark[k] = 1'b0;
         m_wc[k]   = m_wc[k] + 16'd1;
      end
      cyc(2);
      data[k] = d;
      if (full_cyc > 0) begin
         cyc(full_cyc);
         if (k == 0) chk("stall_state", st[k], 3'd3);
         full[k] = 1'b0;
      end
      wait_idle(k);
      chk_regs(k);
   endtask

   // Hold LDAV high through the ACK timeout; optionally keep it high so the
   // level restarts a transfer after holdoff, then complete that one.
   task automatic tmo(input int k, input bit relevel);
      int n;
      logic [14:0] d;
      wait_idle(k);
      raise_ldav(k, n);
      chk("tmo_fall_lat", n, 3);
      n = 0;
      while (!lrfd[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_ack_cycles", n, 16);
      m_te[k] = 1'b1;
      chk("tmo_flag", te[k], 1'b1);
      chk("tmo_wc", wc[k], m_wc[k]);
      if (relevel) begin
         n = 0;
         while (lrfd[k] && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("relevel_lat", n, 10);
         d = 15'($urandom);
         ldav[k] = 1'b0;
         data[k] = d;
         expq[k].push_back({m_mark[k], d});
         m_mark[k] = 1'b0;
         m_wc[k]   = m_wc[k] + 16'd1;
      end else begin
         ldav[k] = 1'b0;
      end
      wait_idle(k);
      chk_regs(k);
   endtask

   task automatic clr_pulse(input int k);
      clr[k] = 1'b1;
      @(negedge clk);
      clr[k] = 1'b0;
      m_dc[k] = '0; m_oe[k] = 1'b0; m_te[k] = 1'b0;
      chk_regs(k);
   endtask

   task automatic en_test(input int k);
      int n;
      logic [14:0] d;
      wait_idle(k);
      en[k]   = 1'b0;
      ldav[k] = 1'b1;
      cyc(20);
      chk("en_block_lrfd", lrfd[k], 1'b1);
      chk("en_block_busy", busy[k], 1'b0);
      en[k] = 1'b1;
      n = 0;
      while (lrfd[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("en_start_lat", n, 1);
      en[k] = 1'b0;                       // ignored once the transfer is running
      d = 15'($urandom);
      ldav[k] = 1'b0;
      data[k] = d;
      expq[k].push_back({m_mark[k], d});
      m_mark[k] = 1'b0;
      m_wc[k]   = m_wc[k] + 16'd1;
      wait_idle(k);
      chk_regs(k);
      en[k] = 1'b1;
   endtask

   task automatic rst_mid(input int k, input logic [2:0] stage);
      int n;
      wait_idle(k);
      raise_ldav(k, n);
      chk("rm_fall_lat", n, 3);
      ldav[k] = 1'b0;
      full[k] = (stage == 3'd3);
      for (int i = 0; i < 40 && st[k] != stage; i++) @(negedge clk);
      chk("rm_reach_state", st[k], stage);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      full[k] = 1'b0;
      model_reset();
      chk_reset_state(0);
      chk_reset_state(1);
   endtask

   // Write monitor / scoreboard
   always @(negedge clk) begin : mon
      logic [15:0] e;
      for (int k = 0; k < 2; k++) begin
         if (we[k] === 1'b1) begin
            chk("write_while_full", full[k], 1'b0);
            if (expq[k].size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = expq[k].pop_front();
               chk("write_data", wd[k], e);
            end
         end
      end
   end

   initial begin : watchdog
      #500us;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, r;
      rst = 1'b1;
      en = 2'b11; clr = 2'b00; ldav = 2'b00; full = 2'b00;
      data[0] = '0; data[1] = '0;
      model_reset();
      cyc(3);
      chk_reset_state(0);
      chk_reset_state(1);
      rst = 1'b0;
      cyc(3);

      xfer(0, 15'h1A5C, 0);
      xfer(0, 15'h7FFF, 0);
      xfer(0, 15'($urandom), 50);

      xfer(1, 15'h0011, 20);
      xfer(1, 15'h0022, 0);
      xfer(1, 15'h0033, 0);
      clr_pulse(1);

      tmo(0, 1'b0);
      tmo(1, 1'b0);
      tmo(0, 1'b1);
      clr_pulse(0);
      en_test(0);

      rst_mid(0, 3'd2);
      xfer(0, 15'($urandom), 0);
      rst_mid(0, 3'd3);
      xfer(0, 15'($urandom), 0);
      xfer(1, 15'($urandom), 0);

      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         if (r < 2)       xfer(k, 15'($urandom), int'($urandom_range(10, 30)));
         else if (r == 2) tmo(k, 1'($urandom));
         else if (r == 3) clr_pulse(k);
         else             xfer(k, 15'($urandom), 0);
      end

      cyc(5);
      chk("queue_empty0", expq[0].size(), 0);
      chk("queue_empty1", expq[1].size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
